// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch FSM: PC, synchronous ROM capture, IR handshake and branch redirect.
// Optional HALT opcode (16'hFFFF) detection is compiled in with `define HALT_DETECT_EN.
module instruction_fetch (
    input  logic        clock_50,
    input  logic        reset_n,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic        ir_ready,
    output logic [7:0]  PC,
    output logic [15:0] IRout,
    output logic        ir_valid,
    output logic        halted
);

`ifdef HALT_DETECT_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_HOLD = 3'd3
    } state_t;
`endif

    state_t state;
    state_t state_nxt;
    logic   redirect;
    logic   advance;
    logic   halt_op;

`ifdef HALT_DETECT_EN
    assign halt_op = (IRout == 16'hFFFF);
`else
    assign halt_op = 1'b0;
`endif

    // A branch outranks a completing handshake; IDLE (and HALT) ignore it.
    assign redirect = branch_taken &&
                      ((state == S_REQ) || (state == S_CAP) || (state == S_HOLD));
    assign advance  = !branch_taken && (state == S_HOLD) && ir_ready && !halt_op;

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ:  state_nxt = branch_taken ? S_REQ : S_CAP;
            S_CAP:  state_nxt = branch_taken ? S_REQ : S_HOLD;
            S_HOLD: begin
                if (branch_taken) begin
                    state_nxt = S_REQ;
                end else if (ir_ready) begin
`ifdef HALT_DETECT_EN
                    state_nxt = halt_op ? S_HALT : S_REQ;
`else
                    state_nxt = S_REQ;
`endif
                end
            end
`ifdef HALT_DETECT_EN
            S_HALT: state_nxt = S_HALT;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ir_valid = (state == S_HOLD);
`ifdef HALT_DETECT_EN
        halted   = (state == S_HALT);
`else
        halted   = 1'b0;
`endif
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            PC <= 8'h00;
        end else if (redirect) begin
            PC <= branch_target;
        end else if (advance) begin
            PC <= PC + 8'd1;
        end
    end

    // A flush leaves the stale instruction here; only a clean CAP->HOLD loads it.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            IRout <= 16'h0000;
        end else if ((state == S_CAP) && !branch_taken) begin
            IRout <= rom_data;
        end
    end

    assign rom_addr = PC;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch against a transaction-level fetch model.
module tb_instruction_fetch;

    logic        clock_50;
    logic        reset_n;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        ir_ready;
    logic [7:0]  PC;
    logic [15:0] IRout;
    logic        ir_valid;
    logic        halted;

    instruction_fetch dut (
        .clock_50      (clock_50),
        .reset_n       (reset_n),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ir_ready      (ir_ready),
        .PC            (PC),
        .IRout         (IRout),
        .ir_valid      (ir_valid),
        .halted        (halted)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    logic [15:0] rom [256];
    always @(posedge clock_50) rom_data <= rom[rom_addr];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Model: address of the instruction being fetched, cycles since the last
    // PC change (-1 = idle after reset), last captured instruction, halt flag.
    int          m_pc;
    int          m_age;
    logic [15:0] m_ir;
    logic        m_halt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_valid();
        return !m_halt && (m_age >= 2);
    endfunction

    task automatic model_reset();
        m_pc   = 0;
        m_age  = -1;
        m_ir   = 16'h0000;
        m_halt = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc"},       {8'h00, PC},       16'h0000);
        chk({tag, "_rom_addr"}, {8'h00, rom_addr}, 16'h0000);
        chk({tag, "_irout"},    IRout,             16'h0000);
        chk({tag, "_ir_valid"}, {15'h0, ir_valid}, 16'h0000);
        chk({tag, "_halted"},   {15'h0, halted},   16'h0000);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock_50);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic cycle(input logic br, input logic [7:0] tgt, input logic rdy);
        logic v;
        v = exp_valid();
        branch_taken  = br;
        branch_target = tgt;
        ir_ready      = rdy;
        if (m_halt) begin
        end else if (m_age < 0) begin
            m_age = 0;
        end else if (br) begin
            m_pc  = tgt;
            m_age = 0;
        end else if (v && rdy) begin
`ifdef HALT_DETECT_EN
            if (m_ir == 16'hFFFF) begin
                m_halt = 1'b1;
            end else begin
                m_pc  = (m_pc + 1) % 256;
                m_age = 0;
            end
`else
            m_pc  = (m_pc + 1) % 256;
            m_age = 0;
`endif
        end else if (!v) begin
            m_age++;
            if (m_age == 2) m_ir = rom[m_pc];
        end
        @(posedge clock_50);
        #1;
        chk("pc",       {8'h00, PC},       16'(m_pc));
        chk("rom_addr", {8'h00, rom_addr}, 16'(m_pc));
        chk("ir_valid", {15'h0, ir_valid}, {15'h0, exp_valid()});
        chk("irout",    IRout,             m_ir);
        chk("halted",   {15'h0, halted},   {15'h0, m_halt});
        branch_taken = 1'b0;
    endtask

    initial begin
        logic [15:0] seq [3];
        seq[0] = 16'h1111;
        seq[1] = 16'h2222;
        seq[2] = 16'h3333;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($urandom);
`ifdef HALT_DETECT_EN
            if (rom[i] == 16'hFFFF) rom[i] = 16'h0000;
`endif
        end
        for (int i = 0; i < 3; i++) rom[i] = seq[i];
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        ir_ready      = 1'b0;
        model_reset();

        do_reset();

        // Streaming with ir_ready held high: valid on edges 3, 6, 9.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (i % 3 == 2) begin
                chk("stream_ir",    IRout,             seq[i / 3]);
                chk("stream_pc",    {8'h00, PC},       16'(i / 3));
                chk("stream_valid", {15'h0, ir_valid}, 16'h0001);
            end
        end

        // Back-pressure for five cycles, then release.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            chk("stall_ir", IRout,       16'h3333);
            chk("stall_pc", {8'h00, PC}, 16'h0002);
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk("release_pc",    {8'h00, PC},       16'h0003);
        chk("release_valid", {15'h0, ir_valid}, 16'h0000);

        // Branch on the same edge as a handshake wins without +1.
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h40, 1'b1);
        chk("br_hs_pc",    {8'h00, PC},       16'h0040);
        chk("br_hs_valid", {15'h0, ir_valid}, 16'h0000);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("br_target_ir",    IRout,             rom[8'h40]);
        chk("br_target_valid", {15'h0, ir_valid}, 16'h0001);

        // PC wrap from 8'hFF to 8'h00.
        cycle(1'b1, 8'hFF, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("wrap_pc", {8'h00, PC}, 16'h0000);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("wrap_ir", IRout, rom[0]);

        // Flush in CAP keeps the stale IRout.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h10, 1'b0);
        chk("flush_ir",    IRout,             rom[0]);
        chk("flush_valid", {15'h0, ir_valid}, 16'h0000);

        // Asynchronous reset pulse inside CAP with no clock edge.
        cycle(1'b0, 8'h00, 1'b0);
        reset_n = 1'b0;
        #2;
        check_zero("async");
        reset_n = 1'b1;
        model_reset();

        // Branch in IDLE is ignored; fetch restarts at address 0.
        cycle(1'b1, 8'h55, 1'b0);
        chk("idle_branch_pc", {8'h00, PC}, 16'h0000);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("restart_ir", IRout, rom[0]);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
        end

`ifdef HALT_DETECT_EN
        rom[3] = 16'hFFFF;
        do_reset();
        for (int i = 0; i < 13; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("halt_flag", {15'h0, halted}, 16'h0001);
        chk("halt_pc",   {8'h00, PC},     16'h0003);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20, 1'b1);
        chk("halt_branch_pc", {8'h00, PC}, 16'h0003);
        do_reset();
`else
        rom[8'h20] = 16'hFFFF;
        cycle(1'b1, 8'h20, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("ffff_ir", IRout, 16'hFFFF);
        cycle(1'b0, 8'h00, 1'b1);
        chk("ffff_pc",     {8'h00, PC},     16'h0021);
        chk("ffff_halted", {15'h0, halted}, 16'h0000);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
